// File: rtl/shift_arbiter_if.sv
// Request/response bundle for the shared barrel-shift arbiter.
// Handshake: a transfer happens on a rising edge where valid & ready are both high; valid never waits on ready, ready may look at valid.
interface shift_arbiter_if #(
  parameter int NUM_REQ = 2,
  parameter int XLEN    = 32
);
  localparam int SW  = $clog2(XLEN);
  localparam int IDW = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]      req_valid;
  logic [NUM_REQ-1:0]      req_ready;
  logic [NUM_REQ*XLEN-1:0] req_data;
  logic [NUM_REQ*SW-1:0]   req_amt;
  logic [NUM_REQ*2-1:0]    req_op;
  logic                    rsp_valid;
  logic                    rsp_ready;
  logic [XLEN-1:0]         rsp_data;
  logic [IDW-1:0]          rsp_id;
  logic                    busy;

  modport master (
    output req_valid, req_data, req_amt, req_op, rsp_ready,
    input  req_ready, rsp_valid, rsp_data, rsp_id, busy
  );

  modport slave (
    input  req_valid, req_data, req_amt, req_op, rsp_ready,
    output req_ready, rsp_valid, rsp_data, rsp_id, busy
  );
endinterface

// File: rtl/shift_arbiter.sv
// Round-robin arbiter sharing one SLL/SRL/SRA datapath among NUM_REQ requesters,
// with a single registered response slot tagged by the winning requester.
module shift_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int XLEN    = 32
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  shift_arbiter_if.slave bus,
  output logic [0:0]   dbg_state
);
  localparam int SW  = $clog2(XLEN);
  localparam int IDW = $clog2(NUM_REQ);

  localparam logic [0:0] EMPTY = 1'b0;
  localparam logic [0:0] FULL  = 1'b1;

  logic [0:0]      state;
  logic [IDW-1:0]  ptr;
  logic [XLEN-1:0] rsp_data_q;
  logic [IDW-1:0]  rsp_id_q;

  logic            slot_free;
  logic            found;
  logic [IDW-1:0]  win_id;
  logic [IDW-1:0]  idx;
  logic [XLEN-1:0] sel_data;
  logic [SW-1:0]   sel_amt;
  logic [1:0]      sel_op;
  logic            accept;
  logic [IDW-1:0]  ptr_next;

  function automatic logic [XLEN-1:0] do_shift(input logic [XLEN-1:0] d,
                                               input logic [SW-1:0]   a,
                                               input logic [1:0]      op);
    case (op)
      2'b01:   return d >> a;
      2'b11:   return $unsigned($signed(d) >>> a);
      default: return d << a;  // 10 is reserved and behaves as SLL
    endcase
  endfunction

  assign slot_free = (state == EMPTY) || bus.rsp_ready;

  // Scan from ptr, wrapping, and keep the first valid requester.
  always_comb begin
    found  = 1'b0;
    win_id = '0;
    idx    = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = IDW'((int'(ptr) + i) % NUM_REQ);
      if (!found && bus.req_valid[idx]) begin
        found  = 1'b1;
        win_id = idx;
      end
    end
  end

  always_comb begin
    sel_data = '0;
    sel_amt  = '0;
    sel_op   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (win_id == IDW'(k)) begin
        sel_data = bus.req_data[k*XLEN +: XLEN];
        sel_amt  = bus.req_amt[k*SW +: SW];
        sel_op   = bus.req_op[k*2 +: 2];
      end
    end
  end

  assign accept   = i_rst_n && found && slot_free;
  assign ptr_next = (win_id == IDW'(NUM_REQ - 1)) ? '0 : win_id + 1'b1;

  always_comb begin
    bus.req_ready = '0;
    if (accept) bus.req_ready[win_id] = 1'b1;
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state      <= EMPTY;
      ptr        <= '0;
      rsp_data_q <= '0;
      rsp_id_q   <= '0;
    end else if (accept) begin
      // Covers drain-and-refill in the same edge: the slot never empties.
      state      <= FULL;
      ptr        <= ptr_next;
      rsp_data_q <= do_shift(sel_data, sel_amt, sel_op);
      rsp_id_q   <= win_id;
    end else if (state == FULL && bus.rsp_ready) begin
      state <= EMPTY;
    end
  end

  assign bus.rsp_valid = (state == FULL);
  assign bus.rsp_data  = rsp_data_q;
  assign bus.rsp_id    = rsp_id_q;
  assign bus.busy      = (state == FULL) && !bus.rsp_ready;
  assign dbg_state     = state;
endmodule

// File: tb/tb_shift_arbiter.sv
// Directed bench for shift_arbiter: reset, shift ops, round-robin,
// backpressure, single requester and mid-operation reset.
module tb_shift_arbiter;
  localparam int NUM_REQ = 2;
  localparam int XLEN    = 32;
  localparam int SW      = 5;

  logic       clk;
  logic       rst_n;
  logic [0:0] dbg_state;
  int         n_tests;
  int         n_fail;
  logic [XLEN:0] exp_q[$];

  shift_arbiter_if #(.NUM_REQ(NUM_REQ), .XLEN(XLEN)) bus ();

  shift_arbiter #(.NUM_REQ(NUM_REQ), .XLEN(XLEN)) dut (
    .i_clk     (clk),
    .i_rst_n   (rst_n),
    .bus       (bus.slave),
    .dbg_state (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_rsp(input string tag, input logic [XLEN-1:0] exp_data, input int exp_id);
    check({tag, "_valid"}, 64'(bus.rsp_valid), 64'd1);
    check({tag, "_id"},    64'(bus.rsp_id), 64'(exp_id));
    check({tag, "_data"},  64'(bus.rsp_data), 64'(exp_data));
  endtask

  // driver
  task automatic set_req(input int k, input logic v, input logic [XLEN-1:0] d,
                         input logic [SW-1:0] a, input logic [1:0] op);
    bus.req_valid[k]             = v;
    bus.req_data[k*XLEN +: XLEN] = d;
    bus.req_amt[k*SW +: SW]      = a;
    bus.req_op[k*2 +: 2]         = op;
  endtask

  logic [XLEN-1:0] t2_data [8] = '{32'h8000_00F0, 32'h8000_00F0, 32'h8000_00F0, 32'h8000_00F0,
                                   32'h7000_0000, 32'h8000_0000, 32'h8000_0000, 32'h0000_0001};
  logic [SW-1:0]   t2_amt  [8] = '{5'd4, 5'd4, 5'd0, 5'd4, 5'd4, 5'd31, 5'd31, 5'd31};
  logic [1:0]      t2_op   [8] = '{2'b01, 2'b11, 2'b11, 2'b10, 2'b11, 2'b01, 2'b11, 2'b00};
  logic [XLEN-1:0] t2_exp  [8] = '{32'h0800_000F, 32'hF800_000F, 32'h8000_00F0, 32'h0000_0F00,
                                   32'h0700_0000, 32'h0000_0001, 32'hFFFF_FFFF, 32'h8000_0000};

  initial begin
    logic [XLEN:0] e;
    n_tests = 0;
    n_fail  = 0;
    rst_n   = 1'b0;
    bus.req_valid = '0;
    bus.req_data  = '0;
    bus.req_amt   = '0;
    bus.req_op    = '0;
    bus.rsp_ready = 1'b0;

    // T1 reset with both requesters valid
    set_req(0, 1'b1, 32'h8000_00F0, 5'd4, 2'b00);
    set_req(1, 1'b1, 32'h0000_0001, 5'd3, 2'b00);
    repeat (2) @(posedge clk);
    #1;
    check("rst_ready", 64'(bus.req_ready), 64'd0);
    check("rst_valid", 64'(bus.rsp_valid), 64'd0);
    check("rst_data",  64'(bus.rsp_data), 64'd0);
    check("rst_id",    64'(bus.rsp_id), 64'd0);
    check("rst_busy",  64'(bus.busy), 64'd0);
    check("rst_state", 64'(dbg_state), 64'd0);
    rst_n = 1'b1;
    bus.rsp_ready = 1'b1;
    #1;
    check("rst_first_grant", 64'(bus.req_ready), 64'b01);
    @(posedge clk); #1;
    check_rsp("t2_sll", 32'h0000_0F00, 0);
    check("t2_state_full", 64'(dbg_state), 64'd1);

    // T2 shift ops on req0 alone
    set_req(1, 1'b0, 32'h0, 5'd0, 2'b00);
    for (int i = 0; i < 8; i++) begin
      set_req(0, 1'b1, t2_data[i], t2_amt[i], t2_op[i]);
      #1;
      check("t2_ready", 64'(bus.req_ready), 64'b01);
      @(posedge clk); #1;
      check_rsp("t2_op", t2_exp[i], 0);
    end

    // T3 round-robin, ptr now at 1
    set_req(0, 1'b1, 32'h0000_0001, 5'd1, 2'b00);
    set_req(1, 1'b1, 32'h0000_0010, 5'd1, 2'b01);
    for (int i = 0; i < 6; i++) begin
      if (i % 2 == 0) exp_q.push_back({1'b1, 32'h0000_0008});
      else            exp_q.push_back({1'b0, 32'h0000_0002});
    end
    for (int i = 0; i < 6; i++) begin
      e = exp_q.pop_front();
      #1;
      check("t3_ready", 64'(bus.req_ready), e[XLEN] ? 64'b10 : 64'b01);
      @(posedge clk); #1;
      check_rsp("t3_rr", e[XLEN-1:0], int'(e[XLEN]));
    end

    // T4 backpressure, slot holds id0 / 0x2
    bus.rsp_ready = 1'b0;
    #1;
    check("t4_ready_low", 64'(bus.req_ready), 64'd0);
    check("t4_busy", 64'(bus.busy), 64'd1);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check_rsp("t4_hold", 32'h0000_0002, 0);
      check("t4_hold_busy", 64'(bus.busy), 64'd1);
      check("t4_hold_ready", 64'(bus.req_ready), 64'd0);
    end
    bus.rsp_ready = 1'b1;
    #1;
    check("t4_release_ready", 64'(bus.req_ready), 64'b10);
    check("t4_release_busy", 64'(bus.busy), 64'd0);
    @(posedge clk); #1;
    check_rsp("t4_refill", 32'h0000_0008, 1);

    // T5 only req1 valid, back-to-back
    set_req(0, 1'b0, 32'h0, 5'd0, 2'b00);
    for (int i = 0; i < 4; i++) begin
      set_req(1, 1'b1, 32'h0000_0100 << i, 5'd8, 2'b01);
      #1;
      check("t5_ready", 64'(bus.req_ready), 64'b10);
      @(posedge clk); #1;
      check_rsp("t5_single", 32'h1 << i, 1);
    end
    set_req(1, 1'b0, 32'h0, 5'd0, 2'b00);
    #1;
    check("t5_idle_ready", 64'(bus.req_ready), 64'd0);
    @(posedge clk); #1;
    check("t5_drain_valid", 64'(bus.rsp_valid), 64'd0);
    check("t5_drain_busy", 64'(bus.busy), 64'd0);
    check("t5_drain_state", 64'(dbg_state), 64'd0);

    // T6 reset while full and stalled
    set_req(0, 1'b1, 32'h0000_0003, 5'd0, 2'b00);
    set_req(1, 1'b1, 32'h0000_0005, 5'd0, 2'b00);
    bus.rsp_ready = 1'b0;
    #1;
    check("t6_ready_empty", 64'(bus.req_ready), 64'b01);
    @(posedge clk); #1;
    check_rsp("t6_fill", 32'h0000_0003, 0);
    check("t6_busy", 64'(bus.busy), 64'd1);
    check("t6_ready_full", 64'(bus.req_ready), 64'd0);
    @(posedge clk); #1;
    check_rsp("t6_stall", 32'h0000_0003, 0);
    rst_n = 1'b0;
    #1;
    check("t6_ready_in_rst", 64'(bus.req_ready), 64'd0);
    @(posedge clk); #1;
    check("t6_rst_valid", 64'(bus.rsp_valid), 64'd0);
    check("t6_rst_data", 64'(bus.rsp_data), 64'd0);
    check("t6_rst_id", 64'(bus.rsp_id), 64'd0);
    check("t6_rst_busy", 64'(bus.busy), 64'd0);
    rst_n = 1'b1;
    bus.rsp_ready = 1'b1;
    #1;
    check("t6_ptr_reset", 64'(bus.req_ready), 64'b01);
    @(posedge clk); #1;
    check_rsp("t6_after_rst", 32'h0000_0003, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
